// File: rtl/rpc_stb_cmd_receiver.sv
// Device-side receiver for the RPC STB serial command stream. It deserialises an
// MSB-first frame while CS# is low and presents it on a one-entry valid/ready output.
module rpc_stb_cmd_receiver #(
    parameter int DRAM_CMD_WIDTH = 32,
    parameter int OPCODE_WIDTH   = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      rpc_cs_ni,
    input  logic                      rpc_stb_i,
    output logic [DRAM_CMD_WIDTH-1:0] cmd_o,
    output logic [OPCODE_WIDTH-1:0]   opcode_o,
    output logic                      cmd_valid_o,
    input  logic                      cmd_ready_i,
    output logic                      frame_err_o,
    output logic                      overrun_o,
    output logic                      busy_o,
    output logic [15:0]               frame_cnt_o
);

    localparam int W  = DRAM_CMD_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        TAIL  = 2'd3
    } state_e;

    state_e          state_q;
    logic [W-1:0]    sr_q;
    logic [CW-1:0]   bit_cnt_q;
    logic [W-1:0]    cmd_q;
    logic            valid_q;
    logic            pend_q;
    logic            frame_err_q;
    logic            overrun_q;
    logic [15:0]     frame_cnt_q;

    logic            handshake_d;
    logic            load_d;
    logic            drop_d;

    // Valid/ready: a frame is consumed on any edge where cmd_valid_o and cmd_ready_i
    // are both high; cmd_o never changes and cmd_valid_o never falls otherwise.
    assign handshake_d = valid_q & cmd_ready_i;
    assign load_d      = (state_q == DONE) & (~valid_q | cmd_ready_i);
    assign drop_d      = (state_q == DONE) & valid_q & ~cmd_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            valid_q     <= 1'b0;
            pend_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            pend_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rpc_cs_ni) begin
                        // The first wire bit ends up at W-1 after the remaining W-1 shifts.
                        sr_q      <= {{(W-1){1'b0}}, rpc_stb_i};
                        bit_cnt_q <= CW'(1);
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rpc_cs_ni) begin
                        frame_err_q <= 1'b1;
                        sr_q        <= '0;
                        bit_cnt_q   <= '0;
                        state_q     <= IDLE;
                    end else begin
                        sr_q      <= {sr_q[W-2:0], rpc_stb_i};
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (bit_cnt_q == CW'(W-1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    bit_cnt_q <= '0;
                    state_q   <= rpc_cs_ni ? IDLE : TAIL;
                end
                TAIL: begin
                    if (rpc_cs_ni) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // The frame lands in cmd_q one edge after DONE; valid follows one edge later.
            if (load_d) begin
                cmd_q       <= sr_q;
                pend_q      <= 1'b1;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (drop_d) begin
                overrun_q <= 1'b1;
            end

            if (pend_q) begin
                valid_q <= 1'b1;
            end else if (handshake_d) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign cmd_o       = cmd_q;
    assign opcode_o    = cmd_q[W-1 -: OPCODE_WIDTH];
    assign cmd_valid_o = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);
    assign frame_cnt_o = frame_cnt_q;

    a_pulses_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(frame_err_o && overrun_o));

    a_hold_while_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (cmd_valid_o && !cmd_ready_i) |=> (cmd_valid_o && $stable(cmd_o)));

endmodule

// File: tb/tb_rpc_stb_cmd_receiver.sv
// Bench for rpc_stb_cmd_receiver: a frame-level reference model checked every cycle,
// plus directed frames with hand-computed literal expectations.
module tb_rpc_stb_cmd_receiver;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          cs_n;
    logic          stb;
    logic          ready;
    logic [W-1:0]  cmd;
    logic [4:0]    opcode;
    logic          valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;
    logic [15:0]   frame_cnt;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    rpc_stb_cmd_receiver #(.DRAM_CMD_WIDTH(W), .OPCODE_WIDTH(5)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rpc_cs_ni   (cs_n),
        .rpc_stb_i   (stb),
        .cmd_o       (cmd),
        .opcode_o    (opcode),
        .cmd_valid_o (valid),
        .cmd_ready_i (ready),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .busy_o      (busy),
        .frame_cnt_o (frame_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the first W low samples of a CS# low run; a run that
    // ends early is an error. The output slot takes the frame one edge after completion
    // (if free or being drained) and raises valid one edge after that.
    int          m_run;
    logic [W-1:0] m_bits;
    logic [W-1:0] m_frame;
    logic        m_done_pend;
    logic        m_rise_pend;
    logic        m_rise_now;
    logic        m_hs;
    logic        m_valid;
    logic [W-1:0] m_cmd;
    logic [15:0] m_cnt;
    logic        m_err;
    logic        m_ovr;

    initial begin
        m_run = 0; m_bits = '0; m_frame = '0; m_done_pend = 0; m_rise_pend = 0;
        m_valid = 0; m_cmd = '0; m_cnt = '0; m_err = 0; m_ovr = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_bits = '0; m_frame = '0; m_done_pend = 0; m_rise_pend = 0;
            m_valid = 0; m_cmd = '0; m_cnt = '0; m_err = 0; m_ovr = 0;
        end else begin
            m_err = 0;
            m_ovr = 0;
            m_hs = m_valid && ready;
            m_rise_now = m_rise_pend;
            m_rise_pend = 0;
            if (m_done_pend) begin
                if (!m_valid || ready) begin
                    m_cmd = m_frame;
                    m_cnt = m_cnt + 16'd1;
                    m_rise_pend = 1;
                end else begin
                    m_ovr = 1;
                end
                m_done_pend = 0;
            end
            if (m_rise_now) m_valid = 1;
            else if (m_hs) m_valid = 0;
            if (!cs_n) begin
                m_run++;
                if (m_run <= W) m_bits = {m_bits[W-2:0], stb};
                if (m_run == W) begin
                    m_frame = m_bits;
                    m_done_pend = 1;
                end
            end else begin
                if (m_run > 0 && m_run < W) m_err = 1;
                m_run = 0;
            end
        end
    end

    // Scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", {31'd0, valid}, {31'd0, m_valid});
            chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
            chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
            chk("busy", {31'd0, busy}, {31'd0, (m_run > 0)});
            chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
            chk("cmd", cmd, m_cmd);
            chk("opcode", {27'd0, opcode}, {27'd0, m_cmd[W-1 -: 5]});
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [W-1:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            cs_n = 1'b0;
            stb  = f[W-1-i];
            tick();
        end
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        stb  = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [W-1:0] f, input int tail);
        shift_bits(f, W);
        for (int i = 0; i < tail; i++) begin
            cs_n = 1'b0;
            stb  = 1'($urandom_range(1, 0));
            tick();
        end
        cs_high();
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst_n = 1'b1;
        cs_n  = 1'b1;
        stb   = 1'b0;
        ready = 1'b1;
        #2 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) tick();
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic frame and latency: last bit at edge N, valid after N+2
        send_frame(32'hA5C3_0F81, 0);
        chk("t1_valid_n1", {31'd0, valid}, 32'd0);
        chk("t1_cnt", {16'd0, frame_cnt}, 32'd1);
        tick();
        chk("t1_valid_n2", {31'd0, valid}, 32'd1);
        chk("t1_cmd", cmd, 32'hA5C3_0F81);
        chk("t1_opcode", {27'd0, opcode}, 32'h14);
        repeat (3) tick();

        // Truncated frames (17 bits and the W-1 boundary), then a good frame
        shift_bits(32'hFFFF_FFFF, 17);
        cs_high();
        chk("t2_err17", {31'd0, frame_err}, 32'd1);
        tick();
        chk("t2_err_pulse", {31'd0, frame_err}, 32'd0);
        shift_bits(32'h7654_3210, 31);
        cs_high();
        chk("t2_err31", {31'd0, frame_err}, 32'd1);
        chk("t2_no_valid", {31'd0, valid}, 32'd0);
        send_frame(32'h1234_5678, 0);
        tick();
        chk("t2_cmd", cmd, 32'h1234_5678);
        chk("t2_cnt", {16'd0, frame_cnt}, 32'd2);
        repeat (2) tick();

        // Back-to-back frames with the consumer stalled
        ready = 1'b0;
        send_frame(32'hDEAD_BEEF, 0);
        send_frame(32'h0BAD_F00D, 0);
        chk("t3_overrun", {31'd0, overrun}, 32'd1);
        chk("t3_cnt", {16'd0, frame_cnt}, 32'd3);
        chk("t3_held", cmd, 32'hDEAD_BEEF);
        tick();
        chk("t3_ovr_pulse", {31'd0, overrun}, 32'd0);
        chk("t3_still_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        tick();
        chk("t3_accepted", {31'd0, valid}, 32'd0);

        // Stalled slot drained in the very cycle the next frame completes
        ready = 1'b0;
        send_frame(32'h1111_2222, 0);
        shift_bits(32'h3333_4444, W);
        ready = 1'b1;
        cs_high();
        chk("t3b_no_ovr", {31'd0, overrun}, 32'd0);
        chk("t3b_cnt", {16'd0, frame_cnt}, 32'd5);
        tick();
        chk("t3b_valid", {31'd0, valid}, 32'd1);
        chk("t3b_cmd", cmd, 32'h3333_4444);
        tick();

        // Long CS# low with random tail
        send_frame(32'h8000_0001, 64);
        chk("t4_cnt", {16'd0, frame_cnt}, 32'd6);
        chk("t4_cmd", cmd, 32'h8000_0001);
        repeat (3) tick();

        // Reset mid-frame
        shift_bits(32'hCAFE_BABE, 20);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("t5_rst_cmd", cmd, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        cs_n = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send_frame(32'h5A5A_A5A5, 0);
        tick();
        chk("t5_cmd", cmd, 32'h5A5A_A5A5);
        chk("t5_opcode", {27'd0, opcode}, 32'h0B);
        chk("t5_cnt", {16'd0, frame_cnt}, 32'd1);
        repeat (2) tick();

        // Frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        tick();
        send_frame(32'h0F0F_F0F0, 0);
        chk("t6_wrap", {16'd0, frame_cnt}, 32'd0);
        repeat (2) tick();
        send_frame(32'h0000_0000, 0);
        chk("t6_after_wrap", {16'd0, frame_cnt}, 32'd1);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
